// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA/character-cell timing generator.
package vga_pkg;

    typedef enum logic [1:0] {
        AXIS_ACTIVE = 2'd0,
        AXIS_FRONT  = 2'd1,
        AXIS_SYNC   = 2'd2,
        AXIS_BACK   = 2'd3
    } axis_state_t;

    localparam logic MODE_A = 1'b0;
    localparam logic MODE_B = 1'b1;

    // clog2 that never returns 0, so single-value counters still get a bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_axis_gen.sv
// One timing axis: ACTIVE (blocks x pixels) -> FRONT -> SYNC -> BACK, advanced by increment.
module vga_axis_gen
    import vga_pkg::*;
#(
    parameter int BLOCKS   = 80,
    parameter int PIXELS   = 10,
    parameter int SYNC_LEN = 4,
    parameter int BACK_LEN = 46,
    parameter int FRONT_W  = 8,
    parameter int BW       = width_of(BLOCKS),
    parameter int PW       = width_of(PIXELS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               increment,
    input  logic [FRONT_W-1:0] front_len,
    output logic               carry,
    output logic               active,
    output logic               sync,
    output logic [BW-1:0]      block,
    output logic [PW-1:0]      pixel
);

    localparam int SW  = width_of(SYNC_LEN + 1);
    localparam int KW  = width_of(BACK_LEN + 1);
    localparam int CW0 = (FRONT_W > SW) ? FRONT_W : SW;
    localparam int CW  = (CW0 > KW) ? CW0 : KW;

    axis_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [BW-1:0] block_reg, block_next;
    logic [PW-1:0] pixel_reg, pixel_next;
    logic [CW-1:0] front_last;

    assign front_last = CW'(front_len) - CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= AXIS_ACTIVE;
            cnt_reg   <= '0;
            block_reg <= '0;
            pixel_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            block_reg <= block_next;
            pixel_reg <= pixel_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        block_next = block_reg;
        pixel_next = pixel_reg;
        carry      = 1'b0;
        if (increment) begin
            case (state_reg)
                AXIS_ACTIVE: begin
                    if (pixel_reg == PW'(PIXELS - 1)) begin
                        pixel_next = '0;
                        if (block_reg == BW'(BLOCKS - 1)) begin
                            block_next = '0;
                            state_next = AXIS_FRONT;
                        end else begin
                            block_next = block_reg + BW'(1);
                        end
                    end else begin
                        pixel_next = pixel_reg + PW'(1);
                    end
                end
                AXIS_FRONT: begin
                    if (cnt_reg == front_last) begin
                        cnt_next   = '0;
                        state_next = AXIS_SYNC;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                AXIS_SYNC: begin
                    if (cnt_reg == CW'(SYNC_LEN - 1)) begin
                        cnt_next   = '0;
                        state_next = AXIS_BACK;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                AXIS_BACK: begin
                    // Last unit of back porch closes the period for the next axis up.
                    if (cnt_reg == CW'(BACK_LEN - 1)) begin
                        cnt_next   = '0;
                        state_next = AXIS_ACTIVE;
                        carry      = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                default: state_next = AXIS_ACTIVE;
            endcase
        end
    end

    assign active = (state_reg == AXIS_ACTIVE);
    assign sync   = (state_reg == AXIS_SYNC);
    assign block  = block_reg;
    assign pixel  = pixel_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Character-cell video timing with mode-switchable porches, delayed DE/syncs and blink.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_BLOCKS        = 80,
    parameter int H_PIXELS        = 10,
    parameter int H_FRONT_A       = 36,
    parameter int H_FRONT_B       = 210,
    parameter int H_SYNC          = 4,
    parameter int H_BACK          = 46,
    parameter int V_BLOCKS        = 24,
    parameter int V_PIXELS        = 20,
    parameter int V_FRONT_A       = 7,
    parameter int V_FRONT_B       = 22,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 23,
    parameter int SYNC_ACTIVE_LOW = 0,
    parameter int DELAY           = 0,
    parameter int BLINK_FRAMES    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mode_sel,
    output logic                          mode_active,
    output logic                          de,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          block,
    output logic [width_of(H_BLOCKS)-1:0] h_block,
    output logic [width_of(H_PIXELS)-1:0] h_pixel,
    output logic [width_of(V_BLOCKS)-1:0] v_block,
    output logic [width_of(V_PIXELS)-1:0] v_pixel,
    output logic                          frame_start,
    output logic                          blink
);

    localparam int   H_FW      = width_of((H_FRONT_A > H_FRONT_B ? H_FRONT_A : H_FRONT_B) + 1);
    localparam int   V_FW      = width_of((V_FRONT_A > V_FRONT_B ? V_FRONT_A : V_FRONT_B) + 1);
    localparam int   FCW       = width_of(BLINK_FRAMES);
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
    localparam logic [3:0] PIPE_RST = {1'b0, SYNC_IDLE, SYNC_IDLE, 1'b0};

    logic            mode_active_reg;
    logic            blink_reg;
    logic [FCW-1:0]  frame_cnt_reg;
    logic            h_eol, eof;
    logic            h_active, v_active, h_sync, v_sync;
    logic [H_FW-1:0] h_front_len;
    logic [V_FW-1:0] v_front_len;
    logic [3:0]      raw_vec, out_vec;

    assign h_front_len = (mode_active_reg == MODE_B) ? H_FW'(H_FRONT_B) : H_FW'(H_FRONT_A);
    assign v_front_len = (mode_active_reg == MODE_B) ? V_FW'(V_FRONT_B) : V_FW'(V_FRONT_A);

    vga_axis_gen #(
        .BLOCKS(H_BLOCKS), .PIXELS(H_PIXELS), .SYNC_LEN(H_SYNC),
        .BACK_LEN(H_BACK), .FRONT_W(H_FW)
    ) u_h_axis (
        .clk(clk), .reset(reset), .increment(1'b1), .front_len(h_front_len),
        .carry(h_eol), .active(h_active), .sync(h_sync),
        .block(h_block), .pixel(h_pixel)
    );

    // The v axis only moves at end of line, so vsync edges align to line boundaries.
    vga_axis_gen #(
        .BLOCKS(V_BLOCKS), .PIXELS(V_PIXELS), .SYNC_LEN(V_SYNC),
        .BACK_LEN(V_BACK), .FRONT_W(V_FW)
    ) u_v_axis (
        .clk(clk), .reset(reset), .increment(h_eol), .front_len(v_front_len),
        .carry(eof), .active(v_active), .sync(v_sync),
        .block(v_block), .pixel(v_pixel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_active_reg <= MODE_A;
            frame_cnt_reg   <= '0;
            blink_reg       <= 1'b0;
        end else if (eof) begin
            mode_active_reg <= mode_sel;
            if (frame_cnt_reg == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt_reg <= '0;
                blink_reg     <= ~blink_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + FCW'(1);
            end
        end
    end

    assign raw_vec = {h_active & v_active,
                      h_sync ^ SYNC_IDLE,
                      v_sync ^ SYNC_IDLE,
                      h_active & v_active & (h_pixel == '0)};

    // Delay stages line DE/syncs up with the latency of memory addressed from the counters.
    generate
        if (DELAY == 0) begin : g_nodelay
            assign out_vec = raw_vec;
        end else begin : g_delay
            for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
                logic [3:0] stage_in;
                logic [3:0] stage_reg;
                if (gi == 0) begin : g_first
                    assign stage_in = raw_vec;
                end else begin : g_next
                    assign stage_in = g_stage[gi-1].stage_reg;
                end
                always_ff @(posedge clk) begin
                    if (reset) stage_reg <= PIPE_RST;
                    else       stage_reg <= stage_in;
                end
            end
            assign out_vec = g_stage[DELAY-1].stage_reg;
        end
    endgenerate

    assign de          = out_vec[3];
    assign hsync       = out_vec[2];
    assign vsync       = out_vec[1];
    assign block       = out_vec[0];
    assign mode_active = mode_active_reg;
    assign blink       = blink_reg;
    assign frame_start = h_active & v_active & (h_block == '0) & (h_pixel == '0)
                         & (v_block == '0) & (v_pixel == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench on a shrunken geometry: line A=19/B=22 clocks, frame A=11/B=13 lines.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HB = 4, HP = 3, HFA = 2, HFB = 5, HS = 2, HK = 3;
    localparam int VB = 3, VP = 2, VFA = 1, VFB = 3, VS = 2, VK = 2;

    logic clk = 1'b0;
    logic reset, mode_sel;
    int   t, checks, errors;

    logic mode0, de0, hs0, vs0, blk0, fs0, blink0;
    logic [width_of(HB)-1:0] hblk0;
    logic [width_of(HP)-1:0] hpix0;
    logic [width_of(VB)-1:0] vblk0;
    logic [width_of(VP)-1:0] vpix0;
    logic mode2, de2, hs2, vs2, blk2, fs2, blink2;
    logic [width_of(HB)-1:0] hblk2;
    logic [width_of(HP)-1:0] hpix2;
    logic [width_of(VB)-1:0] vblk2;
    logic [width_of(VP)-1:0] vpix2;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_BLOCKS(HB), .H_PIXELS(HP), .H_FRONT_A(HFA), .H_FRONT_B(HFB), .H_SYNC(HS), .H_BACK(HK),
        .V_BLOCKS(VB), .V_PIXELS(VP), .V_FRONT_A(VFA), .V_FRONT_B(VFB), .V_SYNC(VS), .V_BACK(VK),
        .SYNC_ACTIVE_LOW(0), .DELAY(0), .BLINK_FRAMES(2)
    ) dut0 (
        .clk(clk), .reset(reset), .mode_sel(mode_sel), .mode_active(mode0),
        .de(de0), .hsync(hs0), .vsync(vs0), .block(blk0),
        .h_block(hblk0), .h_pixel(hpix0), .v_block(vblk0), .v_pixel(vpix0),
        .frame_start(fs0), .blink(blink0)
    );

    vga_timing_gen #(
        .H_BLOCKS(HB), .H_PIXELS(HP), .H_FRONT_A(HFA), .H_FRONT_B(HFB), .H_SYNC(HS), .H_BACK(HK),
        .V_BLOCKS(VB), .V_PIXELS(VP), .V_FRONT_A(VFA), .V_FRONT_B(VFB), .V_SYNC(VS), .V_BACK(VK),
        .SYNC_ACTIVE_LOW(1), .DELAY(2), .BLINK_FRAMES(2)
    ) dut2 (
        .clk(clk), .reset(reset), .mode_sel(mode_sel), .mode_active(mode2),
        .de(de2), .hsync(hs2), .vsync(vs2), .block(blk2),
        .h_block(hblk2), .h_pixel(hpix2), .v_block(vblk2), .v_pixel(vpix2),
        .frame_start(fs2), .blink(blink2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("t=%0d %s observed=%0d expected=%0d", t, tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic step_to(input int target);
        while (t < target) tick();
    endtask

    initial begin
        int  blk_cnt, de_cnt, hs_cnt, de_fall, hs_first, last_blk, gap_bad, blank_blk, lag_bad;
        logic de_h[19], hs_h[19], blk_h[19];
        t = 0; checks = 0; errors = 0;
        reset = 1'b1; mode_sel = MODE_A;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // First cycle after reset release
        check("rst_de0", de0, 1);
        check("rst_fs0", fs0, 1);
        check("rst_hblk0", hblk0, 0);
        check("rst_vblk0", vblk0, 0);
        check("rst_hs0", hs0, 0);
        check("rst_vs0", vs0, 0);
        check("rst_mode0", mode0, 0);
        check("rst_blink0", blink0, 0);
        check("rst_de2", de2, 0);
        check("rst_hs2_idle", hs2, 1);
        check("rst_vs2_idle", vs2, 1);
        check("rst_blk2", blk2, 0);

        // Walk one mode-A line
        blk_cnt = 0; de_cnt = 0; hs_cnt = 0; de_fall = -1; hs_first = -1;
        last_blk = -1; gap_bad = 0; blank_blk = 0; lag_bad = 0;
        for (int i = 0; i < 19; i++) begin
            de_h[i] = de0; hs_h[i] = hs0; blk_h[i] = blk0;
            if (blk0) begin
                if (last_blk >= 0 && (i - last_blk) != HP) gap_bad++;
                if (!de0) blank_blk++;
                last_blk = i;
                blk_cnt++;
            end
            if (de0) de_cnt++;
            else if (de_fall < 0) de_fall = i;
            if (hs0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            if (i >= 2 && (de2 !== de_h[i-2] || blk2 !== blk_h[i-2] || hs2 !== ~hs_h[i-2])) lag_bad++;
            if (i == 1) check("fs0_low_t1", fs0, 0);
            if (i == 1) check("de2_t1", de2, 0);
            if (i == 2) check("de2_t2", de2, 1);
            if (i == 2) check("blk2_t2", blk2, 1);
            if (i == 3) check("hblk0_t3", hblk0, 1);
            if (i == 3) check("blk0_t3", blk0, 1);
            if (i == 16) check("hs2_pulse_low", hs2, 0);
            tick();
        end
        check("blk_count", blk_cnt, HB);
        check("blk_gap_bad", gap_bad, 0);
        check("blk_blanking", blank_blk, 0);
        check("de_clocks", de_cnt, 12);
        check("de_fall_t", de_fall, 12);
        check("hs_width", hs_cnt, HS);
        check("hs_start", hs_first, 14);
        check("delay2_lag", lag_bad, 0);
        check("line1_de0", de0, 1);
        check("line1_vpix0", vpix0, 1);
        step_to(38);
        check("line2_vblk0", vblk0, 1);
        check("line2_vpix0", vpix0, 0);

        step_to(60);
        mode_sel = MODE_B;
        step_to(132); check("vs0_pre", vs0, 0);
        step_to(133); check("vs0_rise", vs0, 1);
        step_to(134); check("vs2_pre", vs2, 1);
        step_to(135); check("vs2_low", vs2, 0);
        step_to(170); check("vs0_last", vs0, 1);
        step_to(171); check("vs0_fall", vs0, 0);
        step_to(208); check("fs0_f0_end", fs0, 0);
        check("mode0_f0_end", mode0, 0);
        step_to(209); check("fs0_f1", fs0, 1);
        check("mode0_f1", mode0, 1);
        check("blink0_f1", blink0, 0);

        // Frame 1 in mode B
        step_to(221); check("de0_fall_B", de0, 0);
        step_to(225); check("hs0_pre_B", hs0, 0);
        step_to(226); check("hs0_rise_B", hs0, 1);
        step_to(228); check("hs0_fall_B", hs0, 0);
        step_to(231); check("de0_line1_B", de0, 1);
        check("vpix0_line1_B", vpix0, 1);
        step_to(300);
        mode_sel = MODE_A;
        step_to(406); check("vs0_pre_B", vs0, 0);
        step_to(407); check("vs0_rise_B", vs0, 1);
        step_to(494); check("fs0_f1_end", fs0, 0);
        check("mode0_f1_end", mode0, 1);
        step_to(495); check("fs0_f2", fs0, 1);
        check("mode0_f2", mode0, 0);
        check("blink0_f2", blink0, 1);
        step_to(704); check("fs0_f3", fs0, 1);
        check("blink0_f3", blink0, 1);
        step_to(913); check("fs0_f4", fs0, 1);
        check("blink0_f4", blink0, 0);

        // Reset in the middle of a delayed hsync pulse on line 3 of frame 4
        step_to(986); check("hs2_mid", hs2, 0);
        check("vblk0_mid", vblk0, 1);
        check("vpix0_mid", vpix0, 1);
        reset = 1'b1;
        tick();
        check("rst2_hs2", hs2, 1);
        check("rst2_de2", de2, 0);
        check("rst2_vblk0", vblk0, 0);
        check("rst2_vpix0", vpix0, 0);
        check("rst2_hblk0", hblk0, 0);
        check("rst2_fs0", fs0, 1);
        reset = 1'b0;
        tick(); check("post_rst_hs2", hs2, 1);
        check("post_rst_hpix0", hpix0, 1);
        tick(); check("post_rst_de2", de2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor of the fixed 800x480 character-cell timing generator. It produces horizontal and vertical timing with explicit sync widths, selectable sync polarity, and two runtime-selectable porch sets (mode A/B) that switch only at frame boundaries. It adds a configurable output delay so DE and syncs line up with downstream glyph-RAM/ROM latency, plus frame_start and blink outputs. It sits between the pixel clock and the text renderer/video PHY.

Parameters:
H_BLOCKS, 80, character cells per line
H_PIXELS, 10, pixels per cell horizontally
H_FRONT_A, 36, h front porch in mode A (27 MHz)
H_FRONT_B, 210, h front porch in mode B (33 MHz)
H_SYNC, 4, hsync width in clocks
H_BACK, 46, h back porch in clocks
V_BLOCKS, 24, cell rows per frame
V_PIXELS, 20, lines per cell row
V_FRONT_A, 7, v front porch lines, mode A
V_FRONT_B, 22, v front porch lines, mode B
V_SYNC, 2, vsync width in lines
V_BACK, 23, v back porch lines
SYNC_ACTIVE_LOW, 0, 1 = hsync/vsync asserted low
DELAY, 0, pipeline stages (0..3) applied to de/hsync/vsync/block
BLINK_FRAMES, 32, frames per blink half-period

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
mode_sel  in  1  requested porch set (0=A, 1=B)
mode_active  out  1  porch set currently in effect
de  out  1  data enable, delayed by DELAY
hsync  out  1  horizontal sync, delayed by DELAY, polarity per SYNC_ACTIVE_LOW
vsync  out  1  vertical sync, delayed by DELAY
block  out  1  de & first pixel of a cell, delayed by DELAY
h_block  out  clog2(H_BLOCKS)  cell column, undelayed
h_pixel  out  clog2(H_PIXELS)  pixel within cell, undelayed
v_block  out  clog2(V_BLOCKS)  cell row, undelayed
v_pixel  out  clog2(V_PIXELS)  line within cell row, undelayed
frame_start  out  1  one-cycle pulse at position (0,0), undelayed
blink  out  1  toggles every BLINK_FRAMES frames

Behaviour:
- Each axis runs its own state machine: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. ACTIVE lasts BLOCKS*PIXELS units; the other states last their parameter length. The unit is clocks for h and lines for v.
- In ACTIVE, pixel counts 0..PIXELS-1; on wrap, block increments. After the last block, the axis moves to FRONT. Outside ACTIVE, block and pixel hold 0.
- The v axis advances only on the last clock of h BACK. v wraps BACK -> ACTIVE on that same clock, which is the end of the frame.
- Undelayed de = h ACTIVE & v ACTIVE.
- Undelayed sync = axis state is SYNC. It is inverted when SYNC_ACTIVE_LOW=1.
- The v sync state is entered and left on h end-of-line boundaries only.
- DELAY register stages sit on de/hsync/vsync/block. Position outputs and frame_start are not delayed, so memory addressed from them lines up with the delayed de.
- mode_sel is sampled only on the end-of-frame clock. mode_active updates on that clock and applies from the next frame. Toggling mode_sel mid-frame has no effect on the current frame.
- frame_start = 1 exactly when both axes are ACTIVE with all counters 0.
- A frame counter increments at end-of-frame. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink toggles.
- Reset values:
  - all counters 0, both axes ACTIVE, mode_active=0, blink=0;
  - the delay pipe is cleared to de=0, block=0, syncs at inactive level;
  - frame_start=1 on the first cycle after reset is released.
- Reset asserted mid-frame or mid-sync forces the reset state on the next edge. No partial sync pulse continues.
- Totals, mode A: line = 800+36+4+46 = 886 clocks; frame = 480+7+2+23 = 512 lines.
- Totals, mode B: line = 1060 clocks; frame = 527 lines.

Decomposition:
- Package vga_pkg:
  - axis state enum (ACTIVE, FRONT, SYNC, BACK);
  - a width helper function (clog2 with minimum 1);
  - mode constants MODE_A=0, MODE_B=1.
- One sub-module, vga_axis_gen, instantiated twice (h with increment=1, v with increment=h end-of-line). Ports: increment, front-porch length input (muxed by mode_active), carry, active, sync, block, pixel. Its sync length and back porch are parameters.

Test Plan:
- Release reset, defaults, DELAY=0 -> de=1, frame_start=1, h_block=0; de falls after exactly 800 clocks; hsync high for exactly 4 clocks starting 36 clocks after de falls; next de rises 886 clocks after the first.
- Run one full frame in mode A -> frame_start pulses are 453632 clocks apart; vsync is high for 2*886 clocks beginning 7 lines after the last active line.
- Set mode_sel=1 at line 100 -> current frame length is unchanged at 453632; mode_active=1 from the next frame, with line=1060 and frame=527 lines (558620 clocks).
- DELAY=2 and SYNC_ACTIVE_LOW=1 -> de/block lag h_block==0 by 2 clocks; hsync idles 1 and pulses 0; reset asserted mid-hsync -> hsync returns to 1 next edge and counters read 0.
- BLINK_FRAMES=2 -> blink toggles every 2 frame_start pulses, reading 0,0,1,1,0.
- Check block over one line -> exactly 80 block pulses per active line, spaced 10 clocks apart; none during blanking.
